// File: rtl/z_core_icache_pkg.sv
// Shared definitions for the instruction-cache fetch controller.
// Holds the controller state encoding and the byte-in-word offset width.
package z_core_icache_pkg;

  localparam int unsigned WORD_OFF_W = 2;
  localparam int unsigned STATE_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_FILL  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

endpackage

// File: rtl/z_core_icache_ctrl_if.sv
// Fetch, cache-array and memory-port signals of the icache controller.
// The slave modport is the controller's view; master is the surrounding system.
interface z_core_icache_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
);

  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_abort;
  logic                  fetch_valid;
  logic [DATA_WIDTH-1:0] fetch_instr;
  logic                  fetch_err;

  logic [ADDR_WIDTH-1:0] cache_addr;
  logic                  cache_wen;
  logic [DATA_WIDTH-1:0] cache_wdata;
  logic [DATA_WIDTH-1:0] cache_rdata;
  logic                  cache_hit;

  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rerr;

  logic                  busy;
  logic [CNT_WIDTH-1:0]  hit_count;
  logic [CNT_WIDTH-1:0]  miss_count;

  modport slave (
    input  fetch_req, fetch_addr, fetch_abort,
    input  cache_rdata, cache_hit,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_rerr,
    output fetch_valid, fetch_instr, fetch_err,
    output cache_addr, cache_wen, cache_wdata,
    output mem_req, mem_addr,
    output busy, hit_count, miss_count
  );

  modport master (
    output fetch_req, fetch_addr, fetch_abort,
    output cache_rdata, cache_hit,
    output mem_gnt, mem_rvalid, mem_rdata, mem_rerr,
    input  fetch_valid, fetch_instr, fetch_err,
    input  cache_addr, cache_wen, cache_wdata,
    input  mem_req, mem_addr,
    input  busy, hit_count, miss_count
  );

endinterface

// File: rtl/z_core_sat_counter.sv
// Event counter that increments by one and holds at all-ones.
// Clear is synchronous and active-low.
module z_core_sat_counter #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 i_clr_n,
  input  logic                 i_inc,
  output logic [CNT_WIDTH-1:0] o_count
);

  logic [CNT_WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!i_clr_n) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + CNT_WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/z_core_icache_ctrl.sv
// Fetch-side controller for a direct-mapped instruction cache: zero-latency
// hits, single-word refill on miss, fetch abort, bus errors and hit/miss counters.
module z_core_icache_ctrl
  import z_core_icache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  z_core_icache_ctrl_if.slave  bus
);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;

  logic                  w_idle;
  logic                  w_hit;
  logic                  w_miss;
  logic                  w_rsp_err;
  logic                  w_late_fill;
  logic                  w_fill;
  logic                  w_fetch_valid;
  logic [DATA_WIDTH-1:0] w_fetch_instr;
  logic                  w_cache_wen;
  logic [DATA_WIDTH-1:0] w_cache_wdata;
  logic [ADDR_WIDTH-1:0] w_cache_addr;
  logic                  w_mem_req;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [CNT_WIDTH-1:0]  w_hit_count;
  logic [CNT_WIDTH-1:0]  w_miss_count;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_miss) begin
            r_addr  <= bus.fetch_addr;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus.mem_gnt) begin
            r_state <= bus.fetch_abort ? S_DRAIN : S_WAIT;
          end else if (bus.fetch_abort) begin
            r_state <= S_IDLE;
          end
        end
        S_WAIT: begin
          // An abort coinciding with the response still fills, but skips FILL.
          if (bus.mem_rvalid) begin
            if (!bus.fetch_abort && !bus.mem_rerr) begin
              r_data  <= bus.mem_rdata;
              r_state <= S_FILL;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (bus.fetch_abort) begin
            r_state <= S_DRAIN;
          end
        end
        S_FILL:  r_state <= S_IDLE;
        S_DRAIN: begin
          if (bus.mem_rvalid) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Same-cycle responses (hit, bus error, late fill) are decoded from state and inputs.
  always_comb begin
    w_idle        = (r_state == S_IDLE);
    w_fill        = (r_state == S_FILL);
    w_hit         = w_idle && bus.fetch_req && bus.cache_hit && !bus.fetch_abort;
    w_miss        = w_idle && bus.fetch_req && !bus.cache_hit && !bus.fetch_abort;
    w_rsp_err     = (r_state == S_WAIT) && bus.mem_rvalid && bus.mem_rerr && !bus.fetch_abort;
    w_late_fill   = (((r_state == S_WAIT) && bus.fetch_abort) || (r_state == S_DRAIN))
                    && bus.mem_rvalid && !bus.mem_rerr;
    w_fetch_valid = w_hit || w_rsp_err || w_fill;
    w_fetch_instr = w_hit ? bus.cache_rdata : (w_fill ? r_data : '0);
    w_cache_wen   = w_fill || w_late_fill;
    w_cache_wdata = w_fill ? r_data : (w_late_fill ? bus.mem_rdata : '0);
    w_cache_addr  = w_idle ? bus.fetch_addr : r_addr;
    w_mem_req     = (r_state == S_REQ);
    w_mem_addr    = w_mem_req ? {r_addr[ADDR_WIDTH-1:WORD_OFF_W], {WORD_OFF_W{1'b0}}} : '0;
  end

  z_core_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hit_cnt (
    .clk     (clk),
    .i_clr_n (rstn),
    .i_inc   (w_hit),
    .o_count (w_hit_count)
  );

  z_core_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss_cnt (
    .clk     (clk),
    .i_clr_n (rstn),
    .i_inc   (w_miss),
    .o_count (w_miss_count)
  );

  assign bus.fetch_valid = w_fetch_valid;
  assign bus.fetch_instr = w_fetch_instr;
  assign bus.fetch_err   = w_rsp_err;
  assign bus.cache_addr  = w_cache_addr;
  assign bus.cache_wen   = w_cache_wen;
  assign bus.cache_wdata = w_cache_wdata;
  assign bus.mem_req     = w_mem_req;
  assign bus.mem_addr    = w_mem_addr;
  assign bus.busy        = !w_idle;
  assign bus.hit_count   = w_hit_count;
  assign bus.miss_count  = w_miss_count;

endmodule

// File: tb/tb_z_core_icache_ctrl.sv
// Bench for z_core_icache_ctrl: emulates the cache array and a memory responder,
// and predicts each fetch's outcome and cycle timing from the transaction rules.
`timescale 1ns/1ps
module tb_z_core_icache_ctrl;

  localparam int unsigned DW     = 32;
  localparam int unsigned AW     = 32;
  localparam int unsigned CW     = 32;
  localparam int unsigned NLINES = 16;

  logic clk;
  logic rstn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  z_core_icache_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  z_core_icache_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int          total;
  int          bad;
  int unsigned exp_hits;
  int unsigned exp_misses;

  // Environment cache array: direct-mapped, index addr[5:2], tag addr[AW-1:6].
  logic          m_v    [NLINES];
  logic [AW-7:0] m_tag  [NLINES];
  logic [DW-1:0] m_data [NLINES];
  logic          model_clr;
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  function automatic int unsigned line_of(input logic [AW-1:0] a);
    return 32'(a[5:2]);
  endfunction

  always_comb begin
    int unsigned l;
    l = line_of(bus.cache_addr);
    bus.cache_hit   = m_v[l] && (m_tag[l] == bus.cache_addr[AW-1:6]);
    bus.cache_rdata = (m_v[l] && (m_tag[l] == bus.cache_addr[AW-1:6])) ? m_data[l] : '0;
  end

  always @(posedge clk) begin
    if (model_clr) begin
      for (int i = 0; i < int'(NLINES); i++) begin
        m_v[i]    <= 1'b0;
        m_tag[i]  <= '0;
        m_data[i] <= '0;
      end
    end else begin
      if (pl_en) begin
        m_v[line_of(pl_addr)]    <= 1'b1;
        m_tag[line_of(pl_addr)]  <= pl_addr[AW-1:6];
        m_data[line_of(pl_addr)] <= pl_data;
      end
      if (bus.cache_wen) begin
        m_v[line_of(bus.cache_addr)]    <= 1'b1;
        m_tag[line_of(bus.cache_addr)]  <= bus.cache_addr[AW-1:6];
        m_data[line_of(bus.cache_addr)] <= bus.cache_wdata;
      end
    end
  end

  task automatic drive_idle();
    bus.fetch_req   = 1'b0;
    bus.fetch_addr  = '0;
    bus.fetch_abort = 1'b0;
    bus.mem_gnt     = 1'b0;
    bus.mem_rvalid  = 1'b0;
    bus.mem_rdata   = '0;
    bus.mem_rerr    = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // One fetch: grant arrives on cycle 1+gnt_dly (if mem_req is up), data rv_dly later.
  task automatic run_fetch(input logic [AW-1:0] addr, input int gnt_dly, input int rv_dly,
                           input logic [DW-1:0] rdata, input bit err, input int abort_at,
                           input string name);
    int c_g, c_r, req_end, last_req, valid_c, fill_c, done, win;
    bit is_hit, miss, granted;
    logic exp_err, e_v, e_w, e_r, e_b;
    logic [DW-1:0] exp_instr;
    logic [AW-1:0] waddr;
    waddr     = {addr[AW-1:2], 2'b00};
    c_g       = 1 + gnt_dly;
    c_r       = c_g + rv_dly;
    is_hit    = m_v[line_of(addr)] && (m_tag[line_of(addr)] == addr[AW-1:6]);
    valid_c   = -1; fill_c = -1; done = 0; last_req = -1; req_end = 0;
    exp_err   = 1'b0; exp_instr = '0; miss = 1'b0;
    if (abort_at == 0) begin
      req_end = 0;
    end else if (is_hit) begin
      valid_c = 0; exp_instr = m_data[line_of(addr)]; exp_hits++;
    end else begin
      miss = 1'b1; exp_misses++;
      if (abort_at >= 1 && abort_at < c_g) begin
        req_end = abort_at; last_req = abort_at; done = abort_at + 1;
      end else if (abort_at >= c_g) begin
        req_end = abort_at; last_req = c_g; done = c_r + 1;
        if (!err) fill_c = c_r;
      end else if (err) begin
        req_end = c_r; last_req = c_g; done = c_r + 1; valid_c = c_r; exp_err = 1'b1;
      end else begin
        req_end = c_r + 1; last_req = c_g; done = c_r + 2; valid_c = c_r + 1;
        fill_c = c_r + 1; exp_instr = rdata;
      end
    end
    win = ((done > 1) ? done : 1) + 1;
    granted = 1'b0;
    for (int c = 0; c <= win; c++) begin
      @(negedge clk);
      bus.fetch_req   = (c <= req_end) && (c != abort_at);
      bus.fetch_addr  = addr;
      bus.fetch_abort = (c == abort_at) && (c <= req_end);
      bus.mem_gnt     = (c == c_g) && bus.mem_req;
      if (bus.mem_gnt) granted = 1'b1;
      bus.mem_rvalid  = granted && (c == c_r);
      bus.mem_rdata   = bus.mem_rvalid ? rdata : '0;
      bus.mem_rerr    = bus.mem_rvalid && err;
      #1;
      e_v = (c == valid_c);
      e_w = (c == fill_c);
      e_r = miss && (c >= 1) && (c <= last_req);
      e_b = miss && (c >= 1) && (c < done);
      total++;
      if (bus.fetch_valid !== e_v) begin
        bad++; $display("FAIL %s fetch_valid c=%0d got=%b exp=%b", name, c, bus.fetch_valid, e_v);
      end
      if (e_v) begin
        total++;
        if (bus.fetch_instr !== exp_instr || bus.fetch_err !== exp_err) begin
          bad++;
          $display("FAIL %s response c=%0d got instr=%h err=%b exp instr=%h err=%b",
                   name, c, bus.fetch_instr, bus.fetch_err, exp_instr, exp_err);
        end
      end
      total++;
      if (bus.cache_wen !== e_w) begin
        bad++; $display("FAIL %s cache_wen c=%0d got=%b exp=%b", name, c, bus.cache_wen, e_w);
      end
      if (e_w) begin
        total++;
        if (bus.cache_wdata !== rdata || bus.cache_addr[AW-1:2] !== addr[AW-1:2]) begin
          bad++;
          $display("FAIL %s fill c=%0d got data=%h addr=%h exp data=%h addr=%h",
                   name, c, bus.cache_wdata, bus.cache_addr, rdata, addr);
        end
      end
      total++;
      if (bus.mem_req !== e_r) begin
        bad++; $display("FAIL %s mem_req c=%0d got=%b exp=%b", name, c, bus.mem_req, e_r);
      end
      if (e_r) begin
        total++;
        if (bus.mem_addr !== waddr) begin
          bad++; $display("FAIL %s mem_addr c=%0d got=%h exp=%h", name, c, bus.mem_addr, waddr);
        end
      end
      total++;
      if (bus.busy !== e_b) begin
        bad++; $display("FAIL %s busy c=%0d got=%b exp=%b", name, c, bus.busy, e_b);
      end
    end
    drive_idle();
    total++;
    if (bus.hit_count !== CW'(exp_hits) || bus.miss_count !== CW'(exp_misses)) begin
      bad++;
      $display("FAIL %s counters got hit=%0d miss=%0d exp hit=%0d miss=%0d",
               name, bus.hit_count, bus.miss_count, exp_hits, exp_misses);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; model_clr = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    drive_idle();
    repeat (3) @(negedge clk);
    rstn = 1'b1; model_clr = 1'b0;
    exp_hits = 0; exp_misses = 0;
    #1;
    total++;
    if ({bus.fetch_valid, bus.fetch_instr, bus.fetch_err, bus.cache_addr, bus.cache_wen,
         bus.cache_wdata, bus.mem_req, bus.mem_addr, bus.busy, bus.hit_count,
         bus.miss_count} !== '0) begin
      bad++;
      $display("FAIL reset outputs got valid=%b wen=%b req=%b busy=%b hit=%0d miss=%0d exp all zero",
               bus.fetch_valid, bus.cache_wen, bus.mem_req, bus.busy, bus.hit_count, bus.miss_count);
    end
  endtask

  task automatic test_cold_miss();
    run_fetch(32'h0000_0100, 0, 2, 32'h0000_0013, 1'b0, -1, "cold_miss");
  endtask

  task automatic test_hit();
    preload(32'h0000_0104, 32'h00A0_0093);
    run_fetch(32'h0000_0104, 0, 1, 32'h0, 1'b0, -1, "hit");
    run_fetch(32'h0000_0100, 0, 1, 32'h0, 1'b0, -1, "refetch_filled");
  endtask

  task automatic test_abort_before_grant();
    run_fetch(32'h0000_0200, 5, 1, 32'h1111_2222, 1'b0, 2, "abort_pre_gnt");
  endtask

  task automatic test_abort_after_grant();
    run_fetch(32'h0000_0244, 0, 2, 32'hDEAD_BEEF, 1'b0, 2, "abort_wait");
    run_fetch(32'h0000_0248, 0, 2, 32'hFEED_0001, 1'b0, 1, "abort_at_gnt");
    run_fetch(32'h0000_024C, 0, 2, 32'hFEED_0002, 1'b0, 3, "abort_with_rvalid");
  endtask

  task automatic test_bus_err();
    run_fetch(32'h0000_0300, 1, 1, 32'h5555_AAAA, 1'b1, -1, "bus_err");
    run_fetch(32'h0000_0300, 0, 1, 32'h0000_0777, 1'b0, -1, "after_err_miss");
  endtask

  task automatic test_reset_mid_refill();
    @(negedge clk);
    bus.fetch_req = 1'b1; bus.fetch_addr = 32'h0000_0380;
    @(negedge clk);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0; rstn = 1'b0;
    #1;
    total++;
    if (bus.busy !== 1'b1) begin
      bad++; $display("FAIL rst_mid busy_before got=%b exp=1", bus.busy);
    end
    @(negedge clk);
    rstn = 1'b1;
    drive_idle();
    exp_hits = 0; exp_misses = 0;
    #1;
    total++;
    if ({bus.fetch_valid, bus.fetch_instr, bus.fetch_err, bus.cache_addr, bus.cache_wen,
         bus.cache_wdata, bus.mem_req, bus.mem_addr, bus.busy, bus.hit_count,
         bus.miss_count} !== '0) begin
      bad++;
      $display("FAIL rst_mid outputs got valid=%b wen=%b req=%b busy=%b hit=%0d miss=%0d exp all zero",
               bus.fetch_valid, bus.cache_wen, bus.mem_req, bus.busy, bus.hit_count, bus.miss_count);
    end
    @(negedge clk);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    #1;
    total++;
    if (bus.cache_wen !== 1'b0 || bus.fetch_valid !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid stray_rvalid got wen=%b valid=%b busy=%b exp 0 0 0",
               bus.cache_wen, bus.fetch_valid, bus.busy);
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_random(input int n);
    logic [AW-1:0] a;
    int ab, g, r;
    for (int i = 0; i < n; i++) begin
      a = 32'h0000_1000 | (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
          | 32'($urandom_range(0, 3));
      g = $urandom_range(0, 3);
      r = $urandom_range(1, 3);
      case ($urandom_range(0, 9))
        6:       ab = 0;
        7, 8, 9: ab = $urandom_range(1, 1 + g + r);
        default: ab = -1;
      endcase
      run_fetch(a, g, r, $urandom, ($urandom_range(0, 5) == 0), ab, "random");
    end
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_abort_before_grant();
    test_abort_after_grant();
    test_bus_err();
    test_reset_mid_refill();
    test_random(80);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/z_core_icache_ctrl.md
Name: z_core_icache_ctrl

Overview:
- Fetch-side controller for the direct-mapped, write-on-fill instruction cache (combinational read, synchronous write).
- Serves core fetch requests from the cache on a hit. On a miss, sequences a single-word refill from the memory bus, writes the fill into the cache, and forwards the word to the core.
- Supports fetch abort (branch redirect) and bus errors, and keeps hit/miss performance counters.
- Sits between the core fetch stage, the cache array and the instruction memory port.

Parameters:
- DATA_WIDTH, 32, instruction/bus data width
- ADDR_WIDTH, 32, byte address width
- CNT_WIDTH, 32, width of each performance counter

Ports:
- clk  in  1  clock
- rstn  in  1  reset; synchronous and active-low
- fetch_req  in  1  core requests instruction at fetch_addr; held until fetch_valid or fetch_abort
- fetch_addr  in  ADDR_WIDTH  byte address of the fetch; bits [1:0] ignored
- fetch_abort  in  1  drop the current fetch (redirect); the core deasserts fetch_req in the same cycle
- fetch_valid  out  1  fetch_instr/fetch_err valid; one-cycle pulse per completed fetch
- fetch_instr  out  DATA_WIDTH  returned instruction
- fetch_err  out  1  bus error on refill; qualifies fetch_valid
- cache_addr  out  ADDR_WIDTH  address driven to cache: fetch_addr in IDLE, latched miss address otherwise
- cache_wen  out  1  cache write enable (fill)
- cache_wdata  out  DATA_WIDTH  fill data
- cache_rdata  in  DATA_WIDTH  cache data_out
- cache_hit  in  1  cache hit for cache_addr
- mem_req  out  1  memory read request; held until mem_gnt
- mem_addr  out  ADDR_WIDTH  word-aligned read address ({miss_addr[ADDR_WIDTH-1:2],2'b00})
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data valid; exactly one per granted request, at least one cycle after the grant
- mem_rdata  in  DATA_WIDTH  read data
- mem_rerr  in  1  read error; qualifies mem_rvalid
- busy  out  1  high in any state except IDLE
- hit_count  out  CNT_WIDTH  completed hit fetches; saturates at all-ones
- miss_count  out  CNT_WIDTH  misses started; saturates at all-ones

Behaviour:
- States:
  - IDLE: no fetch outstanding.
  - REQ: mem_req high, waiting for mem_gnt.
  - WAIT: granted, waiting for mem_rvalid.
  - FILL: one-cycle cache write and response.
  - DRAIN: aborted, waiting to discard an outstanding response.
- Reset (rstn low at a clk edge):
  - State returns to IDLE and both counters clear.
  - All outputs are 0 in the following cycle.
  - Reset wins over all other inputs, including mid-refill; an outstanding bus response after reset is ignored.
- IDLE:
  - cache_addr = fetch_addr.
  - If fetch_req & cache_hit & !fetch_abort: fetch_valid=1 combinationally in the same cycle, fetch_instr=cache_rdata, hit_count+1. Hit latency is 0 cycles.
  - If fetch_req & !cache_hit & !fetch_abort: latch the address, miss_count+1, go to REQ.
- REQ:
  - mem_req=1 with a stable mem_addr.
  - If mem_gnt: go to WAIT, or to DRAIN if fetch_abort is also high that cycle.
  - If fetch_abort without mem_gnt: deassert mem_req, go to IDLE, no bus transaction.
- WAIT:
  - On mem_rvalid & !mem_rerr: register the data, go to FILL.
  - On mem_rvalid & mem_rerr: fetch_valid=1, fetch_err=1, fetch_instr=0 in the same cycle, no cache write, go to IDLE.
  - On fetch_abort: go to DRAIN. If mem_rvalid arrives in the same cycle as the abort, the data is still filled (if no error) but no response is given, and the state goes to IDLE.
- FILL:
  - cache_wen=1, cache_addr=latched address, cache_wdata=fetch_instr=registered data, fetch_valid=1.
  - Go to IDLE.
  - Miss latency from the miss cycle is 3 cycles plus bus wait cycles (REQ 1 cycle, WAIT ≥1, FILL).
- DRAIN:
  - Wait for mem_rvalid.
  - If no error, write the cache (cache_wen pulse in that cycle with mem_rdata). Never assert fetch_valid.
  - Go to IDLE.
  - fetch_req is ignored until back in IDLE.
- A single outstanding bus transaction at most. fetch_valid is never asserted outside the cases above.
- fetch_abort in IDLE has no effect beyond suppressing that cycle's hit or miss.
- Counters increment by 1 per event and hold at all-ones.

Decomposition:
- Shared package z_core_icache_pkg holds:
  - state encoding localparams (S_IDLE=0, S_REQ=1, S_WAIT=2, S_FILL=3, S_DRAIN=4);
  - the word-offset width constant (2).
- One natural sub-module: z_core_sat_counter (CNT_WIDTH, synchronous active-low clear, inc, saturate), instantiated twice for hit and miss.

Test Plan:
- Cold miss: fetch_req with fetch_addr=0x0000_0100, cache_hit=0; mem_gnt on the first REQ cycle; mem_rvalid 2 cycles later with rdata=0x0000_0013 → mem_addr=0x100, one cache_wen pulse with wdata=0x13, fetch_valid with instr=0x13, miss_count=1.
- Hit: cache_hit=1, cache_rdata=0x00A0_0093, fetch_req at 0x104 → fetch_valid in the same cycle with instr=0x00A00093, no mem_req, hit_count increments.
- Abort before grant: miss at 0x200, mem_gnt held 0, fetch_abort on the second REQ cycle → mem_req drops next cycle, state IDLE, no fetch_valid, no cache_wen.
- Abort after grant: abort in WAIT, then rvalid with rdata=0xDEAD_BEEF → cache_wen pulse with 0xDEADBEEF, fetch_valid never asserted, busy low the cycle after.
- Bus error: miss at 0x300, mem_rvalid & mem_rerr → fetch_valid=1, fetch_err=1, fetch_instr=0, no cache_wen.
- Reset mid-refill: rstn low in WAIT → next cycle all outputs 0 and counters 0; a later stray mem_rvalid causes no cache_wen and no fetch_valid.
